// File: rtl/bus_arbiter_2m.sv
// bus_arbiter_2m
// Two-master, round-robin arbiter in front of a single-beat slave bus that
// uses a bstart/bdone handshake (e.g. instruction fetch and load/store
// sharing one boot ROM port).
//
// Optional feature macro: ARB_TIMEOUT_EN
//   When defined, a watchdog in WAIT ends a transfer that the slave never
//   completes and flags it on the granted master's berror output.
//   When undefined, WAIT waits for s_bdone forever and berror is tied 0.

module bus_arbiter_2m #(
    parameter int ADDR_W         = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic              clk,
    input  logic              rst_n,

    // master 0
    input  logic              m0_bstart,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic              m0_write,
    input  logic [31:0]       m0_wdata,
    output logic [31:0]       m0_rdata,
    output logic              m0_bdone,
    output logic              m0_berror,

    // master 1
    input  logic              m1_bstart,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic              m1_write,
    input  logic [31:0]       m1_wdata,
    output logic [31:0]       m1_rdata,
    output logic              m1_bdone,
    output logic              m1_berror,

    // slave
    output logic              s_bstart,
    output logic [ADDR_W-1:0] s_addr,
    output logic              s_write,
    output logic [31:0]       s_wdata,
    input  logic [31:0]       s_rdata,
    input  logic              s_bdone
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } state_t;

    state_t state;
    state_t state_next;

    // grant: master currently owning the slave (0 or 1)
    // last_grant: master served most recently; the other one wins a tie
    logic grant;
    logic grant_next;
    logic last_grant;
    logic last_grant_next;

    // transfer ends this cycle, either by the slave or by the watchdog
    logic xfer_end;
    logic timeout_hit;

`ifdef ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] wait_cnt;

    // Watchdog: cleared while issuing so it starts from 0 on entering WAIT
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt <= '0;
        end else if (state == ISSUE) begin
            wait_cnt <= '0;
        end else if (state == WAIT) begin
            wait_cnt <= wait_cnt + 1'b1;
        end
    end

    // The count reaches TIMEOUT_CYCLES on the WAIT cycle where wait_cnt holds
    // TIMEOUT_CYCLES-1; a slave bdone in that same cycle wins over the timeout.
    assign timeout_hit = (state == WAIT) && !s_bdone &&
                         (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
    assign timeout_hit = 1'b0;
`endif

    // State, grant and round-robin history registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            grant      <= 1'b0;
            last_grant <= 1'b1;
        end else begin
            state      <= state_next;
            grant      <= grant_next;
            last_grant <= last_grant_next;
        end
    end

    // Next-state logic: pick a winner in IDLE, one issue cycle, then wait
    always_comb begin
        state_next      = state;
        grant_next      = grant;
        last_grant_next = last_grant;
        unique case (state)
            IDLE: begin
                if (m0_bstart || m1_bstart) begin
                    if (m0_bstart && m1_bstart) begin
                        grant_next = ~last_grant;
                    end else begin
                        grant_next = m1_bstart;
                    end
                    state_next = ISSUE;
                end
            end
            ISSUE: begin
                state_next = WAIT;
            end
            WAIT: begin
                if (s_bdone || timeout_hit) begin
                    last_grant_next = grant;
                    state_next      = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign xfer_end = (state == WAIT) && (s_bdone || timeout_hit);

    // Slave-side outputs: the granted master's request is routed while the
    // transfer is in flight, and the bus is parked at 0 in IDLE
    always_comb begin
        s_bstart = 1'b0;
        s_addr   = '0;
        s_write  = 1'b0;
        s_wdata  = '0;
        if (state == ISSUE) begin
            s_bstart = 1'b1;
        end
        if (state != IDLE) begin
            if (grant) begin
                s_addr  = m1_addr;
                s_write = m1_write;
                s_wdata = m1_wdata;
            end else begin
                s_addr  = m0_addr;
                s_write = m0_write;
                s_wdata = m0_wdata;
            end
        end
    end

    // Master-side outputs: completion goes only to the granted master
    always_comb begin
        m0_rdata  = s_rdata;
        m1_rdata  = s_rdata;
        m0_bdone  = xfer_end && !grant;
        m1_bdone  = xfer_end && grant;
        m0_berror = timeout_hit && !grant;
        m1_berror = timeout_hit && grant;
    end

endmodule

// File: tb/tb_bus_arbiter_2m.sv
// tb_bus_arbiter_2m
// Directed bench for bus_arbiter_2m with a single-cycle ROM slave model.
// Expected read data is pushed into a scoreboard queue when a request is
// issued; a monitor pops and compares on every master bdone pulse.
// ROM contents: mem[a] = {a[15:0], ~a[15:0]}.

module tb_bus_arbiter_2m;

    logic        clk;
    logic        rst_n;

    logic        bst [2];
    logic [31:0] adr [2];
    logic        wr  [2];
    logic [31:0] wd  [2];

    logic [31:0] m0_rdata, m1_rdata;
    logic        m0_bdone, m1_bdone, m0_berror, m1_berror;
    logic        s_bstart, s_write;
    logic [31:0] s_addr, s_wdata;
    logic [31:0] s_rdata;
    logic        s_bdone;
    logic        s_bdone_reg;
    logic        slave_mute;
    logic        spur_bdone;

    int checks;
    int errors;

    typedef struct {
        int          id;
        logic [31:0] rdata;
        logic        berror;
        logic        rdata_dc;
    } exp_t;

    exp_t sb_q[$];

    bus_arbiter_2m #(
        .ADDR_W(32),
        .TIMEOUT_CYCLES(4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .m0_bstart (bst[0]),
        .m0_addr   (adr[0]),
        .m0_write  (wr[0]),
        .m0_wdata  (wd[0]),
        .m0_rdata  (m0_rdata),
        .m0_bdone  (m0_bdone),
        .m0_berror (m0_berror),
        .m1_bstart (bst[1]),
        .m1_addr   (adr[1]),
        .m1_write  (wr[1]),
        .m1_wdata  (wd[1]),
        .m1_rdata  (m1_rdata),
        .m1_bdone  (m1_bdone),
        .m1_berror (m1_berror),
        .s_bstart  (s_bstart),
        .s_addr    (s_addr),
        .s_write   (s_write),
        .s_wdata   (s_wdata),
        .s_rdata   (s_rdata),
        .s_bdone   (s_bdone)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single-cycle ROM slave: answers one cycle after s_bstart unless muted
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_bdone_reg <= 1'b0;
            s_rdata     <= 32'h0;
        end else begin
            s_bdone_reg <= s_bstart && !slave_mute;
            if (s_bstart) begin
                s_rdata <= {s_addr[15:0], ~s_addr[15:0]};
            end
        end
    end

    assign s_bdone = s_bdone_reg | spur_bdone;

    function automatic logic get_bdone(input int id);
        return (id == 1) ? m1_bdone : m0_bdone;
    endfunction

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic sb_push(input int id, input logic [31:0] rdata, input logic berror, input logic dc);
        exp_t e;
        e.id       = id;
        e.rdata    = rdata;
        e.berror   = berror;
        e.rdata_dc = dc;
        sb_q.push_back(e);
    endtask

    // Monitor: compare every completion against the head of the scoreboard
    always @(negedge clk) begin
        if (rst_n && (m0_bdone || m1_bdone)) begin
            exp_t        e;
            int          act_id;
            logic [31:0] act_rd;
            logic        act_err;
            checks++;
            act_id  = m1_bdone ? 1 : 0;
            act_rd  = m1_bdone ? m1_rdata : m0_rdata;
            act_err = m1_bdone ? m1_berror : m0_berror;
            if (m0_bdone && m1_bdone) begin
                errors++;
                $display("[TB] FAIL bdone_overlap actual=both expected=one");
            end else if (sb_q.size() == 0) begin
                errors++;
                $display("[TB] FAIL unexpected_bdone actual=m%0d rdata=%h expected=none", act_id, act_rd);
            end else begin
                e = sb_q.pop_front();
                if (act_id != e.id || act_err !== e.berror ||
                    (!e.rdata_dc && act_rd !== e.rdata)) begin
                    errors++;
                    $display("[TB] FAIL sb_compare actual=m%0d rdata=%h berr=%b expected=m%0d rdata=%h berr=%b",
                             act_id, act_rd, act_err, e.id, e.rdata, e.berror);
                end
            end
        end
    end

    // One request with cycle-accurate latency checks; call just after a posedge
    task automatic apply_stimulus(input int id, input logic [31:0] a, input logic w,
                                  input logic [31:0] d, input logic [31:0] exp_rd);
        sb_push(id, exp_rd, 1'b0, 1'b0);
        bst[id] = 1'b1;
        adr[id] = a;
        wr[id]  = w;
        wd[id]  = d;
        @(negedge clk);
        check_output("c0_s_bstart", 32'(s_bstart), 32'h0);
        check_output("c0_s_addr", s_addr, 32'h0);
        @(posedge clk); #1;
        @(negedge clk);
        check_output("c1_s_bstart", 32'(s_bstart), 32'h1);
        @(posedge clk); #1;
        @(negedge clk);
        check_output("c2_bdone", 32'(get_bdone(id)), 32'h1);
        check_output("c2_s_addr", s_addr, a);
        check_output("c2_s_write", 32'(s_write), 32'(w));
        check_output("c2_s_wdata", s_wdata, d);
        @(posedge clk); #1;
        bst[id] = 1'b0;
        wr[id]  = 1'b0;
    endtask

    // Master holding bstart across consecutive beats; call just after a posedge
    task automatic master_run(input int id, input logic [31:0] a0, input int count);
        for (int i = 0; i < count; i++) begin
            int k;
            bst[id] = 1'b1;
            adr[id] = a0 + 32'(i * 4);
            k = 0;
            while (k < 40) begin
                @(negedge clk);
                if (get_bdone(id)) break;
                k++;
            end
            if (k >= 40) begin
                checks++;
                errors++;
                $display("[TB] FAIL m%0d_wait_bdone actual=timeout expected=bdone", id);
            end
            @(posedge clk); #1;
        end
        bst[id] = 1'b0;
    endtask

    // Global watchdog so the bench can never hang
    initial begin
        #200000;
        $display("[TB] FAIL global_watchdog actual=running expected=finished");
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed stimulus sequence
    initial begin
        checks     = 0;
        errors     = 0;
        slave_mute = 1'b0;
        spur_bdone = 1'b0;
        for (int i = 0; i < 2; i++) begin
            bst[i] = 1'b0;
            adr[i] = 32'h0;
            wr[i]  = 1'b0;
            wd[i]  = 32'h0;
        end
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_output("rst_outputs",
                     {24'h0, m0_bdone, m1_bdone, m0_berror, m1_berror, s_bstart, s_write, 2'b0},
                     32'h0);
        rst_n = 1'b1;

        // idle after reset: no slave start, everything parked at 0
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check_output("idle_s_bstart", 32'(s_bstart), 32'h0);
        end
        check_output("idle_s_addr", s_addr, 32'h0);
        check_output("idle_s_wdata", s_wdata, 32'h0);
        check_output("idle_flags",
                     {26'h0, m0_bdone, m1_bdone, m0_berror, m1_berror, s_bstart, s_write},
                     32'h0);
        @(posedge clk); #1;

        // lone m0 read of 0x10
        apply_stimulus(0, 32'h0000_0010, 1'b0, 32'h0, 32'h0010_FFEF);

        // lone m1 write to 0x300 (ROM ignores the data, still returns mem[])
        apply_stimulus(1, 32'h0000_0300, 1'b1, 32'hDEAD_BEEF, 32'h0300_FCFF);

        // spurious s_bdone while idle must not reach any master
        spur_bdone = 1'b1;
        @(negedge clk);
        check_output("spur_bdone", {30'h0, m0_bdone, m1_bdone}, 32'h0);
        @(posedge clk); #1;
        spur_bdone = 1'b0;
        @(negedge clk);
        check_output("spur_s_bstart", 32'(s_bstart), 32'h0);
        @(posedge clk); #1;

        // both masters held from the same cycle: m0, m1, m0, m1
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
        sb_push(0, 32'h0100_FEFF, 1'b0, 1'b0);
        sb_push(1, 32'h0200_FDFF, 1'b0, 1'b0);
        sb_push(0, 32'h0104_FEFB, 1'b0, 1'b0);
        sb_push(1, 32'h0204_FDFB, 1'b0, 1'b0);
        fork
            master_run(0, 32'h0000_0100, 2);
            master_run(1, 32'h0000_0200, 2);
        join
        repeat (2) @(posedge clk);
        #1;
        check_output("rr_queue_drained", 32'(sb_q.size()), 32'h0);

        // m1 arrives while m0 is in WAIT: served right after, not lost
        sb_push(0, 32'h0020_FFDF, 1'b0, 1'b0);
        sb_push(1, 32'h0040_FFBF, 1'b0, 1'b0);
        bst[0] = 1'b1;
        adr[0] = 32'h0000_0020;
        @(posedge clk); #1;
        @(posedge clk); #1;
        bst[1] = 1'b1;
        adr[1] = 32'h0000_0040;
        @(negedge clk);
        check_output("pend_c2_bdone", {30'h0, m0_bdone, m1_bdone}, 32'h2);
        @(posedge clk); #1;
        bst[0] = 1'b0;
        @(negedge clk);
        check_output("pend_c3_s_bstart", 32'(s_bstart), 32'h0);
        @(posedge clk); #1;
        @(negedge clk);
        check_output("pend_c4_s_bstart", 32'(s_bstart), 32'h1);
        @(posedge clk); #1;
        @(negedge clk);
        check_output("pend_c5_m1_bdone", 32'(m1_bdone), 32'h1);
        @(posedge clk); #1;
        bst[1] = 1'b0;

        // granted master drops bstart after issue: bdone still delivered
        sb_push(1, 32'h0040_FFBF, 1'b0, 1'b0);
        bst[1] = 1'b1;
        adr[1] = 32'h0000_0040;
        @(posedge clk); #1;
        bst[1] = 1'b0;
        @(negedge clk);
        check_output("drop_c1_s_bstart", 32'(s_bstart), 32'h1);
        @(posedge clk); #1;
        @(negedge clk);
        check_output("drop_c2_m1_bdone", 32'(m1_bdone), 32'h1);
        @(posedge clk); #1;

        // reset in the middle of WAIT, then a fresh m0 transfer
        slave_mute = 1'b1;
        bst[0]     = 1'b1;
        adr[0]     = 32'h0000_0020;
        repeat (3) @(posedge clk);
        #3;
        check_output("wait_s_addr", s_addr, 32'h0000_0020);
        rst_n = 1'b0;
        #1;
        check_output("async_rst_s_addr", s_addr, 32'h0);
        check_output("async_rst_flags", {30'h0, s_bstart, m0_bdone}, 32'h0);
        bst[0]     = 1'b0;
        slave_mute = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        apply_stimulus(0, 32'h0000_0024, 1'b0, 32'h0, 32'h0024_FFDB);

`ifdef ARB_TIMEOUT_EN
        // silent slave: watchdog ends the transfer four cycles after ISSUE
        begin
            int k;
            slave_mute = 1'b1;
            sb_push(0, 32'h0, 1'b1, 1'b1);
            bst[0] = 1'b1;
            adr[0] = 32'h0000_0010;
            k = 0;
            while (k < 20) begin
                @(negedge clk);
                if (m0_bdone) break;
                @(posedge clk); #1;
                k++;
            end
            check_output("to_cycle", 32'(k), 32'd5);
            check_output("to_berror", 32'(m0_berror), 32'h1);
            @(posedge clk); #1;
            bst[0]     = 1'b0;
            slave_mute = 1'b0;
            @(negedge clk);
            check_output("to_idle_s_addr", s_addr, 32'h0);
            @(posedge clk); #1;
        end
`endif

        repeat (3) @(posedge clk);
        #1;
        check_output("final_queue_empty", 32'(sb_q.size()), 32'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
